// File: rtl/fpaddsub_norm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fpaddsub_norm_scheduler
// Description : Shared normalization stage for the FP add/sub datapath.
//               A round-robin arbiter picks one of NREQ lanes per cycle.
//               The chosen lane goes into a two-stage pipeline:
//                 S1 captures the lane's mantissa, exponent and ID.
//                 S2 holds the result: leading-nought count, left shift and
//                    exponent adjust happen between S1 and S2.
//               The result leaves tagged with the originating lane ID.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               req_valid/ready  - per-lane request handshake (NREQ bits)
//               req_mant         - lane i mantissa at [32i+31:32i]
//               req_exp          - lane i biased exponent at [8i+7:8i]
//               out_valid/ready  - result handshake
//               out_id           - originating lane
//               out_mant/exp     - normalized mantissa, adjusted exponent
//               out_zero         - input mantissa was zero
// Revision    : 1.0 - initial release
// ============================================================================
module fpaddsub_norm_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_mant,
  input  logic [NREQ*8-1:0]   req_exp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDW-1:0]      out_id,
  output logic [31:0]         out_mant,
  output logic [7:0]          out_exp,
  output logic                out_zero
);

  localparam int c_mant_w = 32;
  localparam int c_exp_w  = 8;

  // Pipeline state
  logic [IDW-1:0]        ptr_q,       ptr_d;
  logic                  s1_valid_q;
  logic [IDW-1:0]        s1_id_q;
  logic [c_mant_w-1:0]   s1_mant_q;
  logic [c_exp_w-1:0]    s1_exp_q;
  logic                  out_valid_q;
  logic [IDW-1:0]        out_id_q;
  logic [c_mant_w-1:0]   out_mant_q,  out_mant_d;
  logic [c_exp_w-1:0]    out_exp_q,   out_exp_d;
  logic                  out_zero_q,  out_zero_d;

  // Combinational helpers
  logic                  w_s2_en;
  logic                  w_s1_en;
  logic [NREQ-1:0]       w_grant;
  logic [IDW-1:0]        w_grant_idx;
  logic                  w_found;
  logic                  w_xfer;
  logic [c_mant_w-1:0]   w_sel_mant;
  logic [c_exp_w-1:0]    w_sel_exp;
  logic [5:0]            w_lnc;
  logic [c_exp_w-1:0]    w_shift;

  assign w_s2_en = !out_valid_q || out_ready;
  assign w_s1_en = !s1_valid_q || w_s2_en;

  // Round-robin search.
  // Offset k is the priority rank. Lane i sits at rank k exactly when
  // ptr == (i - k) mod NREQ. Every index here is a constant after unrolling,
  // so ptr is only compared, never used as a variable index.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req_valid[i] &&
            (ptr_q == IDW'((i - k + NREQ) % NREQ))) begin
          w_found     = 1'b1;
          w_grant[i]  = 1'b1;
          w_grant_idx = IDW'(i);
        end
      end
    end
  end

  assign req_ready = w_grant & {NREQ{w_s1_en}};
  assign w_xfer    = |req_ready;

  // Steer the granted lane's operands into S1
  always_comb begin
    w_sel_mant = '0;
    w_sel_exp  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_mant = req_mant[c_mant_w*i +: c_mant_w];
        w_sel_exp  = req_exp[c_exp_w*i +: c_exp_w];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (w_xfer) begin
      ptr_d = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + IDW'(1);
    end
  end

  // Leading-nought count: the highest set bit wins because it is visited last
  always_comb begin
    w_lnc = 6'd32;
    for (int b = 0; b < c_mant_w; b++) begin
      if (s1_mant_q[b]) begin
        w_lnc = 6'(31 - b);
      end
    end
  end

  // The shift is clamped to the exponent, so a small exponent leaves a
  // denormal result instead of an underflowed exponent.
  always_comb begin
    w_shift    = ({2'b00, w_lnc} < s1_exp_q) ? {2'b00, w_lnc} : s1_exp_q;
    out_zero_d = (s1_mant_q == '0);
    out_mant_d = s1_mant_q << w_shift;
    out_exp_d  = s1_exp_q - w_shift;
    if (out_zero_d) begin
      out_mant_d = '0;
      out_exp_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_mant_q   <= '0;
      s1_exp_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (w_s1_en) begin
        s1_valid_q <= w_xfer;
        if (w_xfer) begin
          s1_id_q   <= w_grant_idx;
          s1_mant_q <= w_sel_mant;
          s1_exp_q  <= w_sel_exp;
        end
      end
      // The output data holds its last value when a bubble moves in.
      // Only out_valid drops.
      if (w_s2_en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_id_q   <= s1_id_q;
          out_mant_q <= out_mant_d;
          out_exp_q  <= out_exp_d;
          out_zero_q <= out_zero_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_zero  = out_zero_q;

endmodule
`default_nettype wire
